// File: rtl/instr_fetch.sv
// instr_fetch: fetch PC, req/ack program-memory reader and prefetch FIFO feeding the CU.
// Optional: define FETCH_STALL_CNT_EN to add o_stall_cnt (cycles with CU ready but nothing valid).
module instr_fetch #(
    parameter int              ADDR_W   = 8,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    input  logic [7:0]        i_mem_data,
    output logic              o_instr_valid,
    input  logic              i_instr_ready,
    output logic [7:0]        o_instr,
    output logic [3:0]        o_opcode,
    output logic [ADDR_W-1:0] o_instr_pc,
    input  logic              i_jump,
    input  logic [ADDR_W-1:0] i_jump_addr,
    input  logic              i_halt
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]       o_stall_cnt
`endif
);

    // state   | meaning
    // IDLE    | no request outstanding, waiting for a free slot and halt=0
    // FETCH   | request outstanding on o_mem_addr, waiting for i_mem_ack
    // HALTED  | halt seen at end of a fetch; FIFO drains, no new requests
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALTED} state_t;

    localparam int              PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL  = (PTR_W+1)'(DEPTH);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc, w_pc_nxt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_discard;
    logic [7:0]        r_fifo_data [DEPTH];
    logic [ADDR_W-1:0] r_fifo_pc   [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]    r_count, w_count_nxt;
    logic              w_valid, w_ack_fetch, w_push, w_pop, w_issue;

    assign w_valid     = (r_count != '0);
    assign w_ack_fetch = (r_state == S_FETCH) && i_mem_ack;
    assign w_push      = w_ack_fetch && !r_discard && !i_jump;
    assign w_pop       = w_valid && i_instr_ready && !i_jump;

    always_comb begin
        w_count_nxt = r_count;
        if (i_jump) begin
            w_count_nxt = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + (PTR_W+1)'(1);
                2'b01:   w_count_nxt = r_count - (PTR_W+1)'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    always_comb begin
        w_pc_nxt = r_fetch_pc;
        if (i_jump)
            w_pc_nxt = i_jump_addr;
        else if (w_push)
            w_pc_nxt = r_fetch_pc + ADDR_W'(1);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!i_halt && (r_count < FULL))
                    w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (i_mem_ack) begin
                    if (!i_halt && (w_count_nxt < FULL))
                        w_state_nxt = S_FETCH;
                    else if (i_halt)
                        w_state_nxt = S_HALTED;
                    else
                        w_state_nxt = S_IDLE;
                end
            end
            S_HALTED: begin
                if (!i_halt)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A new request latches its address so o_mem_addr holds even if a jump moves the PC.
    assign w_issue = (w_state_nxt == S_FETCH) && ((r_state != S_FETCH) || i_mem_ack);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_mem_addr <= RESET_PC;
            r_discard  <= 1'b0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_pc_nxt;
            r_count    <= w_count_nxt;
            if (w_issue)
                r_mem_addr <= w_pc_nxt;
            if (i_jump && (r_state == S_FETCH) && !i_mem_ack)
                r_discard <= 1'b1;
            else if (w_ack_fetch)
                r_discard <= 1'b0;
            if (i_jump) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= i_mem_data;
            r_fifo_pc[r_wr_ptr]   <= r_fetch_pc;
        end
    end

    assign o_mem_rd      = (r_state == S_FETCH);
    assign o_mem_addr    = r_mem_addr;
    assign o_instr_valid = w_valid;
    assign o_instr       = w_valid ? r_fifo_data[r_rd_ptr] : 8'h00;
    assign o_instr_pc    = w_valid ? r_fifo_pc[r_rd_ptr] : '0;
    assign o_opcode      = o_instr[7:4];

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_stall_cnt <= 16'h0000;
        else if (i_instr_ready && !w_valid && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'h0001;
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboarded bench for instr_fetch: tests queue expected requests/instructions, monitors compare.
// Build with FETCH_STALL_CNT_EN defined to also exercise o_stall_cnt.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_ack;
    logic [7:0] mem_data;
    logic       ready, jump, halt;
    logic [7:0] jump_addr;
    logic       mem_rd, instr_valid;
    logic [7:0] mem_addr, instr, instr_pc;
    logic [3:0] opcode;

    logic       w_rd, w_ack, w_valid, w_en;
    logic [7:0] w_addr, w_data, w_instr, w_pc;
    logic [3:0] w_opc;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt, w_stall;
`endif

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_W(8), .DEPTH(4), .RESET_PC(8'h00)) u_dut (
        .i_clk(clk), .i_rst(rst), .o_mem_rd(mem_rd), .o_mem_addr(mem_addr),
        .i_mem_ack(mem_ack), .i_mem_data(mem_data), .o_instr_valid(instr_valid),
        .i_instr_ready(ready), .o_instr(instr), .o_opcode(opcode), .o_instr_pc(instr_pc),
        .i_jump(jump), .i_jump_addr(jump_addr), .i_halt(halt)
`ifdef FETCH_STALL_CNT_EN
        , .o_stall_cnt(stall_cnt)
`endif
    );

    instr_fetch #(.ADDR_W(8), .DEPTH(4), .RESET_PC(8'hFE)) u_wrap (
        .i_clk(clk), .i_rst(rst), .o_mem_rd(w_rd), .o_mem_addr(w_addr),
        .i_mem_ack(w_ack), .i_mem_data(w_data), .o_instr_valid(w_valid),
        .i_instr_ready(1'b1), .o_instr(w_instr), .o_opcode(w_opc), .o_instr_pc(w_pc),
        .i_jump(1'b0), .i_jump_addr(8'h00), .i_halt(1'b0)
`ifdef FETCH_STALL_CNT_EN
        , .o_stall_cnt(w_stall)
`endif
    );

    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [7:0] mem [256];
    int         lat, acks_left, wait_cnt;
    logic       lat_chk;
    logic [7:0]  exp_addr[$];
    logic [15:0] exp_instr[$];
    int          ack_cyc[$];
    logic [7:0]  wq_addr[$];
    logic [15:0] wq_instr[$];
    logic [15:0] mon_e, wmon_e;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string nm, input logic [31:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got %0h, nothing expected (t=%0t)", nm, act, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // memory model for the main DUT: ack lat cycles after mem_rd, limited by acks_left
    always begin
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        if (!rst && mem_rd && acks_left > 0) begin
            if (wait_cnt >= lat) begin
                mem_ack  = 1'b1;
                mem_data = mem[mem_addr];
                wait_cnt = 0;
                acks_left--;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // memory model for the wrap instance: immediate ack, data = ~addr
    always begin
        @(posedge clk);
        #1;
        w_ack  = w_en && !rst && w_rd;
        w_data = ~w_addr;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rd && mem_ack) begin
                if (exp_addr.size() == 0)
                    unexpected("req_addr", mem_addr);
                else
                    check("req_addr", mem_addr, exp_addr.pop_front());
                if (lat_chk)
                    ack_cyc.push_back(cyc);
            end
            if (instr_valid && ready) begin
                if (exp_instr.size() == 0) begin
                    unexpected("instr", {instr_pc, instr});
                end else begin
                    mon_e = exp_instr.pop_front();
                    check("instr_pc", instr_pc, mon_e[15:8]);
                    check("instr_byte", instr, mon_e[7:0]);
                    check("opcode", opcode, mon_e[7:4]);
                end
                if (lat_chk && ack_cyc.size() > 0)
                    check("ack_to_head_cycles", cyc, ack_cyc.pop_front() + 1);
            end
            if (w_rd && w_ack && wq_addr.size() > 0)
                check("wrap_req_addr", w_addr, wq_addr.pop_front());
            if (w_valid && wq_instr.size() > 0) begin
                wmon_e = wq_instr.pop_front();
                check("wrap_instr_pc", w_pc, wmon_e[15:8]);
                check("wrap_instr_byte", w_instr, wmon_e[7:0]);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        w_en = 1'b0;
        jump = 1'b0;
        halt = 1'b0;
        ready = 1'b0;
        acks_left = 0;
        lat_chk = 1'b0;
        tick(2);
    endtask

    task automatic wait_drain(input string nm, input int max);
        int n = 0;
        while ((exp_addr.size() != 0 || exp_instr.size() != 0) && n < max) begin
            tick(1);
            n++;
        end
        check(nm, exp_addr.size() + exp_instr.size(), 0);
        exp_addr.delete();
        exp_instr.delete();
        ack_cyc.delete();
    endtask

    task automatic wait_ack(input string nm);
        int n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!mem_ack && n < 50);
        check(nm, mem_ack, 1'b1);
    endtask

    initial begin
        int rd_cycles;
        for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
        rst = 1'b1; mem_ack = 1'b0; mem_data = 8'h00; jump_addr = 8'h00;
        w_ack = 1'b0; w_data = 8'h00; lat = 0; wait_cnt = 0;
        do_reset();

        // reset values
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_mem_addr", mem_addr, 8'h00);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 8'h00);
        check("rst_opcode", opcode, 4'h0);
        check("rst_instr_pc", instr_pc, 8'h00);
        check("rst_wrap_mem_addr", w_addr, 8'hFE);
`ifdef FETCH_STALL_CNT_EN
        check("rst_stall_cnt", stall_cnt, 16'h0000);
`endif

        // 1: ack 1 cycle after rd, head appears one cycle after its ack
        mem[0] = 8'h10; mem[1] = 8'h21; mem[2] = 8'h32;
        lat = 1; acks_left = 3; ready = 1'b1; lat_chk = 1'b1;
        exp_addr = '{8'h00, 8'h01, 8'h02};
        exp_instr = '{16'h0010, 16'h0121, 16'h0232};
        rst = 1'b0;
        wait_drain("t1_drain", 60);

        // 2: CU stalled, FIFO fills to DEPTH and fetch stops, then drains and resumes at 4
        do_reset();
        mem[0] = 8'hA0; mem[1] = 8'hB1; mem[2] = 8'hC2; mem[3] = 8'hD3; mem[4] = 8'hE4;
        lat = 0; acks_left = 4;
        exp_addr = '{8'h00, 8'h01, 8'h02, 8'h03};
        rst = 1'b0;
        tick(12);
        check("t2_four_reqs_left", exp_addr.size(), 0);
        check("t2_rd_stopped", mem_rd, 1'b0);
        check("t2_valid_full", instr_valid, 1'b1);
        exp_addr = '{8'h04};
        exp_instr = '{16'h00A0, 16'h01B1, 16'h02C2, 16'h03D3, 16'h04E4};
        acks_left = 1;
        ready = 1'b1;
        wait_drain("t2_drain", 60);

        // 3: PC wraps FF -> 00 from RESET_PC=FE
        do_reset();
        wq_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        wq_instr = '{16'hFE01, 16'hFF00, 16'h00FF, 16'h01FE};
        w_en = 1'b1;
        rst = 1'b0;
        tick(20);
        check("t3_wrap_left", wq_addr.size() + wq_instr.size(), 0);
        w_en = 1'b0;
        wq_addr.delete();
        wq_instr.delete();

        // 4a: jump while a request is outstanding
        do_reset();
        mem[0] = 8'h55; mem[8'h40] = 8'h7C;
        lat = 3; acks_left = 2; ready = 1'b1;
        exp_addr = '{8'h00, 8'h40};
        exp_instr = '{16'h407C};
        rst = 1'b0;
        tick(1);
        jump = 1'b1; jump_addr = 8'h40;
        tick(1);
        jump = 1'b0;
        check("t4a_addr_held", mem_addr, 8'h00);
        check("t4a_rd_held", mem_rd, 1'b1);
        wait_ack("t4a_ack_seen");
        tick(1);
        check("t4a_valid_after_drop", instr_valid, 1'b0);
        check("t4a_next_addr", mem_addr, 8'h40);
        check("t4a_next_rd", mem_rd, 1'b1);
        wait_drain("t4a_drain", 40);

        // 4b: jump on the same edge as the ack
        do_reset();
        lat = 3; acks_left = 2; ready = 1'b1;
        exp_addr = '{8'h00, 8'h40};
        exp_instr = '{16'h407C};
        rst = 1'b0;
        wait_ack("t4b_ack_seen");
        jump = 1'b1; jump_addr = 8'h40;
        tick(1);
        jump = 1'b0;
        check("t4b_valid_after_drop", instr_valid, 1'b0);
        check("t4b_next_addr", mem_addr, 8'h40);
        check("t4b_next_rd", mem_rd, 1'b1);
        wait_drain("t4b_drain", 40);

        // 5: halt mid-fetch completes the request, then no fetch until halt drops
        do_reset();
        mem[0] = 8'h3A; mem[1] = 8'h4B;
        lat = 2; acks_left = 2; ready = 1'b1;
        exp_addr = '{8'h00, 8'h01};
        exp_instr = '{16'h003A, 16'h014B};
        rst = 1'b0;
        tick(1);
        halt = 1'b1;
        wait_ack("t5_ack_seen");
        tick(1);
        rd_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            if (mem_rd) rd_cycles++;
            tick(1);
        end
        check("t5_rd_while_halted", rd_cycles, 0);
        check("t5_drained", instr_valid, 1'b0);
        check("t5_first_entry_popped", exp_instr.size(), 1);
        halt = 1'b0;
        wait_drain("t5_drain", 40);

`ifdef FETCH_STALL_CNT_EN
        // 6: stall counter with silent memory
        do_reset();
        ready = 1'b1;
        rst = 1'b0;
        tick(10);
        check("t6_stall_cnt", stall_cnt, 16'd10);
`endif

        // 7: asynchronous reset in the middle of activity
        do_reset();
        mem[0] = 8'h91; mem[1] = 8'h92; mem[2] = 8'h93; mem[3] = 8'h94;
        lat = 0; acks_left = 4;
        exp_addr = '{8'h00, 8'h01};
        rst = 1'b0;
        tick(3);
        check("t7_pre_valid", instr_valid, 1'b1);
        check("t7_pre_rd", mem_rd, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("t7_async_mem_rd", mem_rd, 1'b0);
        check("t7_async_mem_addr", mem_addr, 8'h00);
        check("t7_async_valid", instr_valid, 1'b0);
        check("t7_async_instr", instr, 8'h00);
        check("t7_async_opcode", opcode, 4'h0);
        check("t7_async_instr_pc", instr_pc, 8'h00);
`ifdef FETCH_STALL_CNT_EN
        check("t7_async_stall_cnt", stall_cnt, 16'h0000);
`endif
        check("t7_reqs_before_rst", exp_addr.size(), 0);
        exp_addr.delete();
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
